// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and widths for the alarm controller slice.
//   - alarm_state_e : controller FSM states
//   - *_W           : time-of-day field widths and snooze counter width
//   - max_int       : helper used to size the shared countdown
package alarm_pkg;

   localparam int HOUR_W    = 5;
   localparam int MIN_W     = 6;
   localparam int SEC_W     = 6;
   localparam int SNZ_CNT_W = 3;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } alarm_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sec_countdown.sv
// sec_countdown: loadable seconds down-counter shared by ring timeout and snooze.
//   clk, rst_n  : clock, async active-low reset (count cleared)
//   tick_i      : 1 Hz enable; decrements by one, saturating at 0
//   load_i      : load load_val_i (takes priority over a tick in the same cycle)
//   zero_o      : count is 0
//   one_o       : count is 1 (the next tick brings it to 0)
module sec_countdown #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         tick_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o,
   output logic         one_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       cnt_q <= '0;
      else if (load_i)                  cnt_q <= load_val_i;
      else if (tick_i && cnt_q != '0)   cnt_q <= cnt_q - W'(1);
   end

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: compares time-of-day against the alarm setpoint on each
// 1 Hz tick and sequences ringing / snooze / dismiss for the relay timer stage.
//   clk, rst_n                   : clock, async active-low reset
//   tick_1hz                     : one-cycle pulse per second
//   cur_hour/cur_min/cur_sec     : current time (binary)
//   alarm_hour/alarm_min         : setpoint (binary)
//   alarm_enable                 : level, 1 = armed; 0 forces DISABLED
//   snooze_req, dismiss_req      : one-cycle user pulses
//   alarm_trigger                : one-cycle pulse on every entry to RINGING
//   ringing, snoozing            : state indicators
//   snooze_count                 : snoozes used in the current alarm event
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int SNOOZE_SEC       = 300,
   parameter int MAX_SNOOZE       = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick_1hz,
   input  logic [HOUR_W-1:0]    cur_hour,
   input  logic [MIN_W-1:0]     cur_min,
   input  logic [SEC_W-1:0]     cur_sec,
   input  logic [HOUR_W-1:0]    alarm_hour,
   input  logic [MIN_W-1:0]     alarm_min,
   input  logic                 alarm_enable,
   input  logic                 snooze_req,
   input  logic                 dismiss_req,
   output logic                 alarm_trigger,
   output logic                 ringing,
   output logic                 snoozing,
   output logic [SNZ_CNT_W-1:0] snooze_count
);

   localparam int CNT_W = $clog2(max_int(RING_TIMEOUT_SEC, SNOOZE_SEC) + 1);

   alarm_state_e         state_q, state_d;
   logic [SNZ_CNT_W-1:0] snz_q, snz_d;
   logic                 trig_q, ring_q, snzing_q;
   logic                 load;
   logic [CNT_W-1:0]     load_val;
   logic                 cnt_zero, cnt_one;
   logic                 match, expire;

   // Out-of-range times can never equal a valid setpoint, and cur_sec==0
   // keeps a dismissed alarm from re-firing later in the same minute.
   assign match  = tick_1hz && (cur_hour == alarm_hour) &&
                   (cur_min == alarm_min) && (cur_sec == '0);
   // Expiry is the tick that brings the count to 0 (or finds it already there).
   assign expire = tick_1hz && (cnt_zero || cnt_one);

   sec_countdown #(.W(CNT_W)) u_cd (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick_1hz),
      .load_i     (load),
      .load_val_i (load_val),
      .zero_o     (cnt_zero),
      .one_o      (cnt_one)
   );

   always_comb begin
      state_d  = state_q;
      snz_d    = snz_q;
      load     = 1'b0;
      load_val = '0;
      if (!alarm_enable) begin
         state_d = DISABLED;
         snz_d   = '0;
         load    = 1'b1;
      end else begin
         unique case (state_q)
            DISABLED: state_d = ARMED;
            ARMED: begin
               if (match) begin
                  state_d  = RINGING;
                  snz_d    = '0;
                  load     = 1'b1;
                  load_val = CNT_W'(RING_TIMEOUT_SEC);
               end
            end
            RINGING: begin
               if (dismiss_req) begin
                  state_d = ARMED;
                  snz_d   = '0;
               end else if (snooze_req) begin
                  if (snz_q < SNZ_CNT_W'(MAX_SNOOZE)) begin
                     state_d  = SNOOZE;
                     snz_d    = snz_q + SNZ_CNT_W'(1);
                     load     = 1'b1;
                     load_val = CNT_W'(SNOOZE_SEC);
                  end else begin
                     state_d = ARMED;
                     snz_d   = '0;
                  end
               end else if (expire) begin
                  state_d = ARMED;
                  snz_d   = '0;
               end
            end
            SNOOZE: begin
               if (dismiss_req) begin
                  state_d = ARMED;
                  snz_d   = '0;
               end else if (expire) begin
                  state_d  = RINGING;
                  load     = 1'b1;
                  load_val = CNT_W'(RING_TIMEOUT_SEC);
               end
            end
            default: state_d = DISABLED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= DISABLED;
         snz_q    <= '0;
         trig_q   <= 1'b0;
         ring_q   <= 1'b0;
         snzing_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         snz_q    <= snz_d;
         trig_q   <= (state_d == RINGING) && (state_q != RINGING);
         ring_q   <= (state_d == RINGING);
         snzing_q <= (state_d == SNOOZE);
      end
   end

   assign alarm_trigger = trig_q;
   assign ringing       = ring_q;
   assign snoozing      = snzing_q;
   assign snooze_count  = snz_q;

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz;
   logic [4:0] cur_hour, alarm_hour;
   logic [5:0] cur_min, cur_sec, alarm_min;
   logic       alarm_enable, snooze_req, dismiss_req;
   logic       alarm_trigger, ringing, snoozing;
   logic [2:0] snooze_count;

   int n_chk  = 0;
   int n_pass = 0;
   int trig_total = 0;
   int snap;
   logic prev_trig = 1'b0;
   logic dbl = 1'b0;

   always #5 clk = ~clk;

   alarm_controller #(
      .RING_TIMEOUT_SEC (4),
      .SNOOZE_SEC       (2),
      .MAX_SNOOZE       (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick_1hz      (tick_1hz),
      .cur_hour      (cur_hour),
      .cur_min       (cur_min),
      .cur_sec       (cur_sec),
      .alarm_hour    (alarm_hour),
      .alarm_min     (alarm_min),
      .alarm_enable  (alarm_enable),
      .snooze_req    (snooze_req),
      .dismiss_req   (dismiss_req),
      .alarm_trigger (alarm_trigger),
      .ringing       (ringing),
      .snoozing      (snoozing),
      .snooze_count  (snooze_count)
   );

   // Pulse bookkeeping sampled mid-cycle
   always @(negedge clk) begin
      if (alarm_trigger) trig_total <= trig_total + 1;
      if (alarm_trigger && prev_trig) dbl <= 1'b1;
      prev_trig <= alarm_trigger;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   // {trigger, ringing, snoozing, snooze_count}
   function automatic logic [5:0] outs();
      return {alarm_trigger, ringing, snoozing, snooze_count};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_at(input int h, input int m, input int s);
      cur_hour = 5'(h);
      cur_min  = 6'(m);
      cur_sec  = 6'(s);
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
   endtask

   task automatic pulse_snooze();
      snooze_req = 1'b1;
      step();
      snooze_req = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; tick_1hz = 1'b0; snooze_req = 1'b0; dismiss_req = 1'b0;
      alarm_enable = 1'b0;
      alarm_hour = 5'd7; alarm_min = 6'd30;
      cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
      step(); step();
      chk("reset_outs", 32'(outs()), 32'h00);

      // Basic match
      rst_n = 1'b1; alarm_enable = 1'b1;
      step();
      tick_at(7, 29, 59);
      chk("no_match_0729", 32'(outs()), 32'h00);
      tick_at(7, 30, 0);
      chk("match_trig", 32'(outs()), 32'b110000);
      step();
      chk("trig_one_cycle", 32'(outs()), 32'b010000);

      // Auto-dismiss after 4 ticks
      for (int i = 1; i <= 3; i++) begin
         tick_at(7, 30, i);
         chk($sformatf("still_ring_%0d", i), 32'(outs()), 32'b010000);
      end
      snap = trig_total;
      tick_at(7, 30, 4);
      chk("auto_dismiss", 32'(outs()), 32'h00);
      tick_at(7, 30, 5);
      chk("nonzero_sec_no_match", 32'(outs()), 32'h00);
      chk("no_trig_after_dismiss", 32'(trig_total - snap), 32'd0);

      // Snooze limit: entry plus three re-rings
      snap = trig_total;
      tick_at(7, 30, 0);
      chk("snz_ring", 32'(outs()), 32'b110000);
      step();
      for (int k = 1; k <= 3; k++) begin
         pulse_snooze();
         chk($sformatf("snz_enter_%0d", k), 32'(outs()), {26'd0, 3'b001, 3'(k)});
         tick_at(7, 31, 2 * k);
         chk($sformatf("snz_wait_%0d", k), 32'(outs()), {26'd0, 3'b001, 3'(k)});
         tick_at(7, 31, 2 * k + 1);
         chk($sformatf("rering_%0d", k), 32'(outs()), {26'd0, 3'b110, 3'(k)});
         step();
         chk($sformatf("rering_hold_%0d", k), 32'(outs()), {26'd0, 3'b010, 3'(k)});
      end
      pulse_snooze();
      chk("snz_over_limit", 32'(outs()), 32'h00);
      chk("snz_trig_count", 32'(trig_total - snap), 32'd4);

      // Dismiss wins over snooze in the same cycle
      tick_at(7, 30, 0);
      step();
      dismiss_req = 1'b1; snooze_req = 1'b1;
      step();
      dismiss_req = 1'b0; snooze_req = 1'b0;
      chk("dismiss_prio", 32'(outs()), 32'h00);

      // Disable during snooze
      tick_at(7, 30, 0);
      step();
      pulse_snooze();
      chk("dis_pre_snooze", 32'(outs()), 32'b001001);
      snap = trig_total;
      alarm_enable = 1'b0;
      step();
      chk("dis_outs", 32'(outs()), 32'h00);
      tick_at(7, 31, 0);
      tick_at(7, 31, 1);
      step();
      chk("dis_after_expiry", 32'(outs()), 32'h00);
      tick_at(7, 30, 0);
      chk("dis_match_ignored", 32'(outs()), 32'h00);
      chk("dis_no_trig", 32'(trig_total - snap), 32'd0);

      // Async reset mid-ringing
      alarm_enable = 1'b1;
      step();
      tick_at(7, 30, 0);
      step();
      chk("rst_pre_ring", 32'(outs()), 32'b010000);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_drop", 32'(outs()), 32'h00);
      alarm_enable = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      tick_at(7, 30, 0);
      chk("rst_no_trig_disabled", 32'(outs()), 32'h00);
      alarm_enable = 1'b1;
      step();
      tick_at(7, 30, 0);
      chk("rst_fresh_match", 32'(outs()), 32'b110000);
      step();
      chk("no_double_trig", 32'(dbl), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Upstream alarm sequencer that drives the relay timer stage.
- Compares time-of-day against a programmed alarm setpoint on each 1 Hz tick and manages ringing, snooze and dismiss.
- Emits a one-cycle alarm_trigger pulse each time ringing starts; the relay stage consumes this pulse.

Parameters:
- RING_TIMEOUT_SEC, 60: seconds RINGING lasts with no user action before auto-dismiss.
- SNOOZE_SEC, 300: seconds spent in SNOOZE before ringing again.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; a snooze beyond this acts as dismiss.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick_1hz  in  1  one-cycle pulse per second, synchronous to clk
- cur_hour  in  5  current hour, binary 0-23
- cur_min  in  6  current minute, binary 0-59
- cur_sec  in  6  current second, binary 0-59
- alarm_hour  in  5  setpoint hour, binary 0-23
- alarm_min  in  6  setpoint minute, binary 0-59
- alarm_enable  in  1  level; 1 = alarm armed
- snooze_req  in  1  one-cycle debounced pulse
- dismiss_req  in  1  one-cycle debounced pulse
- alarm_trigger  out  1  one-cycle pulse on every entry to RINGING
- ringing  out  1  high while in RINGING
- snoozing  out  1  high while in SNOOZE
- snooze_count  out  3  snoozes used in the current alarm event

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - All outputs are registered.
- Reset (rst_n=0):
  - state=DISABLED.
  - alarm_trigger=0, ringing=0, snoozing=0, snooze_count=0.
  - Countdown is cleared.
- Match condition:
  - tick_1hz=1 and cur_hour==alarm_hour and cur_min==alarm_min and cur_sec==0.
  - Evaluated only in the cycle where tick_1hz is high.
- States and transitions:
  - DISABLED -> ARMED when alarm_enable=1. Takes 1 cycle.
  - ARMED -> RINGING on match.
    - alarm_trigger=1 in the cycle after the match cycle (latency 1).
    - Countdown loads RING_TIMEOUT_SEC; snooze_count=0.
  - RINGING:
    - Countdown decrements on each tick_1hz.
    - dismiss_req -> ARMED, snooze_count=0.
    - snooze_req with snooze_count<MAX_SNOOZE -> SNOOZE; snooze_count increments; countdown loads SNOOZE_SEC.
    - snooze_req with snooze_count==MAX_SNOOZE is treated as dismiss.
    - Countdown reaches 0 on a tick -> ARMED (auto-dismiss), snooze_count=0.
  - SNOOZE:
    - Countdown decrements on each tick_1hz.
    - Countdown reaches 0 on a tick -> RINGING; alarm_trigger pulses next cycle; countdown loads RING_TIMEOUT_SEC.
    - dismiss_req -> ARMED, snooze_count=0.
    - snooze_req is ignored.
- alarm_enable=0 in any state:
  - Next state is DISABLED.
  - ringing, snoozing and snooze_count are cleared.
  - No trigger is issued.
  - This has priority over all other events.
- Simultaneous events:
  - Priority order: enable-low > dismiss_req > snooze_req > countdown expiry > match.
  - Snooze expiry in the same tick as a match: exactly one alarm_trigger pulse.
- Match while RINGING or SNOOZE: ignored; setpoint changes do not affect the active event.
- Re-trigger protection: after a dismiss within the alarm minute, there is no re-trigger that day, because the match requires cur_sec==0.
- alarm_trigger:
  - Never high for two consecutive cycles.
  - Never asserted outside an entry to RINGING.
- Countdown:
  - Width is clog2(max(RING_TIMEOUT_SEC, SNOOZE_SEC)+1).
  - Saturates at 0, with no wrap-around.
- Out-of-range time inputs (hour>23, min>59) simply never match; no error flag.
- rst_n asserted mid-RINGING:
  - Outputs drop immediately, asynchronously.
  - After release the block is in DISABLED.

Decomposition:
- Shared package alarm_pkg:
  - State enum: DISABLED, ARMED, RINGING, SNOOZE.
  - Width constants: HOUR_W=5, MIN_W=6, SEC_W=6, SNZ_CNT_W=3.
- One sub-module, sec_countdown:
  - Loadable down-counter enabled by tick_1hz, with a zero flag.
  - Shared by ring timeout and snooze.

Test Plan:
- Basic match:
  - Stimulus: enable=1, alarm 07:30, time steps 07:29:59 -> 07:30:00 with a tick.
  - Response: alarm_trigger high for exactly 1 cycle, one cycle after the tick; ringing=1.
- Auto-dismiss:
  - Stimulus: RING_TIMEOUT_SEC=4, ring, then 4 ticks with no input.
  - Response: ringing falls after the 4th tick; state ARMED; no further trigger.
- Snooze limit:
  - Stimulus: MAX_SNOOZE=3, SNOOZE_SEC=2; ring; repeat snooze and wait 2 ticks.
  - Response: triggers at entry plus 3 re-rings (4 pulses total); snooze_count reaches 3; the 4th snooze ends ringing with snooze_count=0.
- Priority:
  - Stimulus: dismiss_req and snooze_req in the same cycle while RINGING.
  - Response: ARMED, snoozing=0, snooze_count=0.
- Disable:
  - Stimulus: enable dropped during SNOOZE, then countdown expiry.
  - Response: DISABLED; no trigger; all outputs 0.
- Async reset:
  - Stimulus: rst_n pulled low mid-RINGING between clock edges.
  - Response: ringing=0 immediately; after release, no trigger until enable=1 and a fresh match.
